// File: rtl/aud_session_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_session_pkg
// Brief    : Shared types, default geometry and slot-size helper for the
//            audio record/playback session controller.
// Revision : 1.0  initial release
// ============================================================================
package aud_session_pkg;

    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_ADDR_W    = 20;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_RECD       = 3'd2,
        ST_RECD_PAUSE = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5,
        ST_LOOP       = 3'd6
    } state_t;

    // Words per slot: the SRAM address space split evenly across the slots.
    function automatic logic [63:0] slot_size(input int addr_w, input int num_slots);
        return (64'd1 << addr_w) / 64'(num_slots);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aud_session_if.sv
`default_nettype none
// ============================================================================
// Module   : aud_session_if
// Brief    : Key, recorder/DSP handshake and slot status bundle of the
//            session controller; master = controller side.
// Revision : 1.0  initial release
// ============================================================================
interface aud_session_if #(
    parameter int NUM_SLOTS = aud_session_pkg::DEF_NUM_SLOTS,
    parameter int ADDR_W    = aud_session_pkg::DEF_ADDR_W
);
    logic                          i_key_rec;
    logic                          i_key_play;
    logic                          i_key_stop;
    logic                          i_key_slot;
    logic                          i_loop;
    logic [ADDR_W-1:0]             i_rec_addr;
    logic                          i_rec_fin;
    logic                          i_play_fin;

    logic                          o_rec_start;
    logic                          o_rec_pause;
    logic                          o_rec_stop;
    logic                          o_dsp_start;
    logic                          o_dsp_pause;
    logic                          o_dsp_stop;
    logic [$clog2(NUM_SLOTS)-1:0]  o_slot;
    logic [ADDR_W-1:0]             o_slot_base;
    logic [ADDR_W-1:0]             o_slot_end;
    logic [NUM_SLOTS-1:0]          o_slot_valid;
    logic                          o_sram_we_n;
    logic [2:0]                    o_state;

    modport master (
        input  i_key_rec, i_key_play, i_key_stop, i_key_slot, i_loop,
               i_rec_addr, i_rec_fin, i_play_fin,
        output o_rec_start, o_rec_pause, o_rec_stop,
               o_dsp_start, o_dsp_pause, o_dsp_stop,
               o_slot, o_slot_base, o_slot_end, o_slot_valid,
               o_sram_we_n, o_state
    );

    modport slave (
        output i_key_rec, i_key_play, i_key_stop, i_key_slot, i_loop,
               i_rec_addr, i_rec_fin, i_play_fin,
        input  o_rec_start, o_rec_pause, o_rec_stop,
               o_dsp_start, o_dsp_pause, o_dsp_stop,
               o_slot, o_slot_base, o_slot_end, o_slot_valid,
               o_sram_we_n, o_state
    );

endinterface
`default_nettype wire

// File: rtl/aud_slot_table.sv
`default_nettype none
// ============================================================================
// Module   : aud_slot_table
// Brief    : Per-slot recorded end address and valid flag, with write,
//            clear and indexed read.
// Revision : 1.0  initial release
// ============================================================================
module aud_slot_table
    import aud_session_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  wire logic                         i_clk,
    input  wire logic                         i_rst_n,
    input  wire logic                         i_wr_en,
    input  wire logic [$clog2(NUM_SLOTS)-1:0] i_wr_idx,
    input  wire logic [ADDR_W-1:0]            i_wr_end,
    input  wire logic                         i_wr_valid,
    input  wire logic                         i_clr_en,
    input  wire logic [$clog2(NUM_SLOTS)-1:0] i_clr_idx,
    input  wire logic [$clog2(NUM_SLOTS)-1:0] i_rd_idx,
    output logic      [ADDR_W-1:0]            o_rd_end,
    output logic      [NUM_SLOTS-1:0]         o_valid
);
    localparam int c_slot_w = $clog2(NUM_SLOTS);

    logic [ADDR_W-1:0] w_end [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic [ADDR_W-1:0] r_end;
        logic              r_valid;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_end   <= '0;
                r_valid <= 1'b0;
            end else if (i_wr_en && (i_wr_idx == c_slot_w'(g))) begin
                r_end   <= i_wr_end;
                r_valid <= i_wr_valid;
            end else if (i_clr_en && (i_clr_idx == c_slot_w'(g))) begin
                r_valid <= 1'b0;
            end
        end

        assign w_end[g]   = r_end;
        assign o_valid[g] = r_valid;
    end

    assign o_rd_end = w_end[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/aud_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aud_session_ctrl
// Brief    : Record / pause / play / loop session FSM over NUM_SLOTS equal
//            SRAM slots, driving recorder and DSP control levels.
// Revision : 1.0  initial release
// ============================================================================
module aud_session_ctrl
    import aud_session_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst_n,
    input  wire logic      i_i2c_fin,
    aud_session_if.master  bus
);
    localparam int                c_slot_w       = $clog2(NUM_SLOTS);
    localparam int                c_low_w        = ADDR_W - c_slot_w;
    localparam logic [ADDR_W-1:0] c_slot_ofs_max = ADDR_W'(slot_size(ADDR_W, NUM_SLOTS) - 64'd1);

    state_t              r_state, w_state_nxt;
    logic [c_slot_w-1:0] r_slot, w_slot_nxt;
    logic                r_rec_start, r_rec_pause, r_rec_stop;
    logic                r_dsp_start, r_dsp_pause, r_dsp_stop;
    logic                r_sram_we_n;
    logic                w_rec_start_nxt, w_rec_pause_nxt, w_rec_stop_nxt;
    logic                w_dsp_start_nxt, w_dsp_pause_nxt, w_dsp_stop_nxt;
    logic                w_sram_we_n_nxt;

    logic [ADDR_W-1:0]    w_slot_base, w_slot_last, w_slot_end;
    logic [NUM_SLOTS-1:0] w_slot_valid;
    logic                 w_rec_full, w_rec_end, w_play_end;
    logic                 w_from_rec, w_from_play;
    logic                 w_tbl_wr, w_tbl_clr, w_rec_nonempty;

    assign w_slot_base    = ADDR_W'(r_slot) << c_low_w;
    assign w_slot_last    = w_slot_base | c_slot_ofs_max;
    assign w_rec_full     = (bus.i_rec_addr == w_slot_last);
    assign w_rec_end      = bus.i_key_stop | bus.i_rec_fin | w_rec_full;
    assign w_play_end     = bus.i_key_stop | (bus.i_play_fin & ~bus.i_loop);
    assign w_rec_nonempty = (bus.i_rec_addr != w_slot_base);

    assign w_from_rec  = (r_state == ST_RECD) || (r_state == ST_RECD_PAUSE);
    assign w_from_play = (r_state == ST_PLAY) || (r_state == ST_PLAY_PAUSE);
    assign w_tbl_wr    = w_from_rec && (w_state_nxt == ST_IDLE);
    assign w_tbl_clr   = (r_state == ST_IDLE) && (w_state_nxt == ST_RECD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_INIT;
            r_slot      <= '0;
            r_rec_start <= 1'b0;
            r_rec_pause <= 1'b0;
            r_rec_stop  <= 1'b0;
            r_dsp_start <= 1'b0;
            r_dsp_pause <= 1'b0;
            r_dsp_stop  <= 1'b0;
            r_sram_we_n <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_slot      <= w_slot_nxt;
            r_rec_start <= w_rec_start_nxt;
            r_rec_pause <= w_rec_pause_nxt;
            r_rec_stop  <= w_rec_stop_nxt;
            r_dsp_start <= w_dsp_start_nxt;
            r_dsp_pause <= w_dsp_pause_nxt;
            r_dsp_stop  <= w_dsp_stop_nxt;
            r_sram_we_n <= w_sram_we_n_nxt;
        end
    end

    // Only the highest-priority key (stop > rec > play > slot) is considered.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        case (r_state)
            ST_INIT: begin
                if (i_i2c_fin) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.i_key_stop) begin
                    if (bus.i_key_rec) begin
                        w_state_nxt = ST_RECD;
                    end else if (bus.i_key_play) begin
                        if (w_slot_valid[r_slot]) w_state_nxt = ST_PLAY;
                    end else if (bus.i_key_slot) begin
                        w_slot_nxt = r_slot + c_slot_w'(1);
                    end
                end
            end
            ST_RECD: begin
                if (w_rec_end)          w_state_nxt = ST_IDLE;
                else if (bus.i_key_rec) w_state_nxt = ST_RECD_PAUSE;
            end
            ST_RECD_PAUSE: begin
                if (bus.i_key_stop)     w_state_nxt = ST_IDLE;
                else if (bus.i_key_rec) w_state_nxt = ST_RECD;
            end
            ST_PLAY: begin
                if (w_play_end)          w_state_nxt = ST_IDLE;
                else if (bus.i_play_fin) w_state_nxt = ST_LOOP;
                else if (bus.i_key_play) w_state_nxt = ST_PLAY_PAUSE;
            end
            ST_PLAY_PAUSE: begin
                if (bus.i_key_stop)      w_state_nxt = ST_IDLE;
                else if (bus.i_key_play) w_state_nxt = ST_PLAY;
            end
            ST_LOOP: begin
                w_state_nxt = ST_PLAY;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Control levels are held between transitions and updated only on one.
    always_comb begin
        w_rec_start_nxt = r_rec_start;
        w_rec_pause_nxt = r_rec_pause;
        w_rec_stop_nxt  = r_rec_stop;
        w_dsp_start_nxt = r_dsp_start;
        w_dsp_pause_nxt = r_dsp_pause;
        w_dsp_stop_nxt  = r_dsp_stop;
        w_sram_we_n_nxt = (w_state_nxt != ST_RECD);
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_RECD: begin
                    w_rec_start_nxt = 1'b1;
                    w_rec_pause_nxt = 1'b0;
                    w_rec_stop_nxt  = 1'b0;
                end
                ST_RECD_PAUSE: begin
                    w_rec_start_nxt = 1'b0;
                    w_rec_pause_nxt = 1'b1;
                end
                ST_PLAY: begin
                    w_dsp_start_nxt = 1'b1;
                    w_dsp_pause_nxt = 1'b0;
                    w_dsp_stop_nxt  = 1'b0;
                end
                ST_PLAY_PAUSE: begin
                    w_dsp_start_nxt = 1'b0;
                    w_dsp_pause_nxt = 1'b1;
                end
                ST_LOOP: begin
                    w_dsp_start_nxt = 1'b0;
                    w_dsp_stop_nxt  = 1'b1;
                end
                ST_IDLE: begin
                    if (w_from_rec) begin
                        w_rec_start_nxt = 1'b0;
                        w_rec_pause_nxt = 1'b0;
                        w_rec_stop_nxt  = 1'b1;
                    end else if (w_from_play) begin
                        w_dsp_start_nxt = 1'b0;
                        w_dsp_pause_nxt = 1'b0;
                        w_dsp_stop_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    aud_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .ADDR_W    (ADDR_W)
    ) u_slot_table (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (w_tbl_wr),
        .i_wr_idx   (r_slot),
        .i_wr_end   (bus.i_rec_addr),
        .i_wr_valid (w_rec_nonempty),
        .i_clr_en   (w_tbl_clr),
        .i_clr_idx  (r_slot),
        .i_rd_idx   (r_slot),
        .o_rd_end   (w_slot_end),
        .o_valid    (w_slot_valid)
    );

    assign bus.o_rec_start  = r_rec_start;
    assign bus.o_rec_pause  = r_rec_pause;
    assign bus.o_rec_stop   = r_rec_stop;
    assign bus.o_dsp_start  = r_dsp_start;
    assign bus.o_dsp_pause  = r_dsp_pause;
    assign bus.o_dsp_stop   = r_dsp_stop;
    assign bus.o_slot       = r_slot;
    assign bus.o_slot_base  = w_slot_base;
    assign bus.o_slot_end   = w_slot_end;
    assign bus.o_slot_valid = w_slot_valid;
    assign bus.o_sram_we_n  = r_sram_we_n;
    assign bus.o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_aud_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_session_ctrl
// Brief    : Directed scenarios plus randomized key/pulse traffic checked
//            against a behavioural session model.
// Revision : 1.0  initial release
// ============================================================================
module tb_aud_session_ctrl;
    import aud_session_pkg::*;

    localparam int NSLOT   = 4;
    localparam int AW      = 20;
    localparam int SLOT_SZ = (1 << AW) / NSLOT;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic i2c_fin = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    aud_session_if #(.NUM_SLOTS(NSLOT), .ADDR_W(AW)) bus ();

    aud_session_ctrl #(.NUM_SLOTS(NSLOT), .ADDR_W(AW)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_i2c_fin (i2c_fin),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model of the session
    state_t          m_state;
    int              m_slot;
    bit [NSLOT-1:0]  m_valid;
    int              m_end [NSLOT];
    bit              m_rec_start, m_rec_pause, m_rec_stop;
    bit              m_dsp_start, m_dsp_pause, m_dsp_stop;
    bit              m_we_n;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else             n_pass++;
    endtask

    task automatic model_reset();
        m_state = ST_INIT;
        m_slot  = 0;
        m_valid = '0;
        for (int i = 0; i < NSLOT; i++) m_end[i] = 0;
        {m_rec_start, m_rec_pause, m_rec_stop} = 3'b000;
        {m_dsp_start, m_dsp_pause, m_dsp_stop} = 3'b000;
        m_we_n = 1'b1;
    endtask

    task automatic rec_go();     m_rec_start = 1; m_rec_pause = 0; m_rec_stop = 0; endtask
    task automatic rec_halt();   m_rec_start = 0; m_rec_pause = 0; m_rec_stop = 1; endtask
    task automatic play_go();    m_dsp_start = 1; m_dsp_pause = 0; m_dsp_stop = 0; endtask
    task automatic play_halt();  m_dsp_start = 0; m_dsp_pause = 0; m_dsp_stop = 1; endtask

    task automatic save_recording(input int addr);
        m_end[m_slot]   = addr;
        m_valid[m_slot] = (addr != m_slot * SLOT_SZ);
    endtask

    task automatic model_step();
        state_t nxt;
        int     addr;
        bit     rec_end, play_end;
        nxt      = m_state;
        addr     = int'(bus.i_rec_addr);
        rec_end  = bus.i_key_stop || bus.i_rec_fin || (addr == m_slot * SLOT_SZ + SLOT_SZ - 1);
        play_end = bus.i_key_stop || (bus.i_play_fin && !bus.i_loop);
        case (m_state)
            ST_INIT: if (i2c_fin) nxt = ST_IDLE;
            ST_IDLE: if (!bus.i_key_stop) begin
                if (bus.i_key_rec) begin
                    nxt = ST_RECD; m_valid[m_slot] = 1'b0; rec_go();
                end else if (bus.i_key_play) begin
                    if (m_valid[m_slot]) begin nxt = ST_PLAY; play_go(); end
                end else if (bus.i_key_slot) begin
                    m_slot = (m_slot + 1) % NSLOT;
                end
            end
            ST_RECD: begin
                if (rec_end) begin
                    nxt = ST_IDLE; save_recording(addr); rec_halt();
                end else if (bus.i_key_rec) begin
                    nxt = ST_RECD_PAUSE; m_rec_pause = 1; m_rec_start = 0;
                end
            end
            ST_RECD_PAUSE: begin
                if (bus.i_key_stop) begin
                    nxt = ST_IDLE; save_recording(addr); rec_halt();
                end else if (bus.i_key_rec) begin
                    nxt = ST_RECD; rec_go();
                end
            end
            ST_PLAY: begin
                if (play_end) begin
                    nxt = ST_IDLE; play_halt();
                end else if (bus.i_play_fin) begin
                    nxt = ST_LOOP; m_dsp_stop = 1; m_dsp_start = 0;
                end else if (bus.i_key_play) begin
                    nxt = ST_PLAY_PAUSE; m_dsp_pause = 1; m_dsp_start = 0;
                end
            end
            ST_PLAY_PAUSE: begin
                if (bus.i_key_stop) begin
                    nxt = ST_IDLE; play_halt();
                end else if (bus.i_key_play) begin
                    nxt = ST_PLAY; play_go();
                end
            end
            ST_LOOP: begin nxt = ST_PLAY; play_go(); end
            default: nxt = ST_INIT;
        endcase
        m_state = nxt;
        m_we_n  = (nxt != ST_RECD);
    endtask

    task automatic compare_all();
        check_val("state",      32'(bus.o_state),      32'(m_state));
        check_val("slot",       32'(bus.o_slot),       32'(m_slot));
        check_val("slot_base",  32'(bus.o_slot_base),  32'(m_slot * SLOT_SZ));
        check_val("slot_end",   32'(bus.o_slot_end),   32'(m_end[m_slot]));
        check_val("slot_valid", 32'(bus.o_slot_valid), 32'(m_valid));
        check_val("rec_ctl",    32'({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop}),
                                32'({m_rec_start, m_rec_pause, m_rec_stop}));
        check_val("dsp_ctl",    32'({bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop}),
                                32'({m_dsp_start, m_dsp_pause, m_dsp_stop}));
        check_val("sram_we_n",  32'(bus.o_sram_we_n),  32'(m_we_n));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
        bus.i_key_rec  = 1'b0;
        bus.i_key_play = 1'b0;
        bus.i_key_stop = 1'b0;
        bus.i_key_slot = 1'b0;
        bus.i_rec_fin  = 1'b0;
        bus.i_play_fin = 1'b0;
    endtask

    task automatic press(input bit kr, input bit kp, input bit ks, input bit kn);
        bus.i_key_rec  = kr;
        bus.i_key_play = kp;
        bus.i_key_stop = ks;
        bus.i_key_slot = kn;
        step();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
    endtask

    initial begin
        int k;
        int base;
        bus.i_key_rec  = 1'b0;
        bus.i_key_play = 1'b0;
        bus.i_key_stop = 1'b0;
        bus.i_key_slot = 1'b0;
        bus.i_loop     = 1'b0;
        bus.i_rec_addr = '0;
        bus.i_rec_fin  = 1'b0;
        bus.i_play_fin = 1'b0;
        model_reset();

        // Reset state
        step();
        step();
        check_val("rst_state", 32'(bus.o_state), 32'(ST_INIT));
        check_val("rst_we_n",  32'(bus.o_sram_we_n), 32'd1);
        rst_n = 1'b1;

        // Keys ignored in INIT, then first cycle with codec done enters IDLE
        press(1, 0, 0, 0);
        check_val("s1_init_hold", 32'(bus.o_state), 32'(ST_INIT));
        check_val("s1_no_start",  32'(bus.o_rec_start), 32'd0);
        i2c_fin = 1'b1;
        step();
        check_val("s1_idle", 32'(bus.o_state), 32'(ST_IDLE));

        // Slot key wraps 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            press(0, 0, 0, 1);
            check_val("s6_slot_wrap", 32'(bus.o_slot), 32'((i + 1) % 4));
        end

        // Slot 2 recording stopped by key
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        check_val("s2_base", 32'(bus.o_slot_base), 32'h80000);
        bus.i_rec_addr = 20'h80000;
        press(1, 0, 0, 0);
        check_val("s2_recd",  32'(bus.o_state), 32'(ST_RECD));
        check_val("s2_we_n",  32'(bus.o_sram_we_n), 32'd0);
        bus.i_rec_addr = 20'h80123;
        step();
        press(0, 0, 1, 0);
        check_val("s2_end",   32'(bus.o_slot_end), 32'h80123);
        check_val("s2_valid", 32'(bus.o_slot_valid), 32'b0100);

        // Slot 0 auto-stop when the write address reaches the slot's last word
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        bus.i_rec_addr = 20'h0;
        press(1, 0, 0, 0);
        for (int a = 32'h3FFF0; a <= 32'h3FFFF; a++) begin
            bus.i_rec_addr = 20'(a);
            step();
        end
        check_val("s3_state",    32'(bus.o_state), 32'(ST_IDLE));
        check_val("s3_rec_stop", 32'(bus.o_rec_stop), 32'd1);
        check_val("s3_end",      32'(bus.o_slot_end), 32'h3FFFF);
        check_val("s3_valid",    32'(bus.o_slot_valid), 32'b0101);

        // Play on empty slot 1 ignored; slot 2 looped playback
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        check_val("s4_empty_idle",  32'(bus.o_state), 32'(ST_IDLE));
        check_val("s4_empty_start", 32'(bus.o_dsp_start), 32'd0);
        press(0, 0, 0, 1);
        bus.i_loop = 1'b1;
        press(0, 1, 0, 0);
        check_val("s4_play_start", 32'(bus.o_dsp_start), 32'd1);
        step();
        bus.i_play_fin = 1'b1;
        step();
        check_val("s4_loop_state", 32'(bus.o_state), 32'(ST_LOOP));
        check_val("s4_loop_stop",  32'(bus.o_dsp_stop), 32'd1);
        check_val("s4_loop_start", 32'(bus.o_dsp_start), 32'd0);
        step();
        check_val("s4_replay_state", 32'(bus.o_state), 32'(ST_PLAY));
        check_val("s4_replay_start", 32'(bus.o_dsp_start), 32'd1);
        press(0, 0, 1, 0);

        // Stop outranks rec in IDLE
        press(1, 0, 1, 0);
        check_val("s5_idle", 32'(bus.o_state), 32'(ST_IDLE));

        // Randomized traffic, at most one key per cycle
        for (int n = 0; n < 800; n++) begin
            k = int'($urandom_range(0, 9));
            bus.i_key_rec  = (k == 0);
            bus.i_key_play = (k == 1);
            bus.i_key_stop = (k == 2);
            bus.i_key_slot = (k == 3);
            bus.i_rec_fin  = ($urandom_range(0, 15) == 0);
            bus.i_play_fin = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) bus.i_loop = ~bus.i_loop;
            base = m_slot * SLOT_SZ;
            case ($urandom_range(0, 11))
                0:       bus.i_rec_addr = 20'(base + SLOT_SZ - 1);
                1:       bus.i_rec_addr = 20'(base);
                2:       bus.i_rec_addr = 20'($urandom);
                default: bus.i_rec_addr = 20'(base + int'($urandom_range(1, 4095)));
            endcase
            step();
        end

        // Reset mid-record discards the slot and restarts cleanly
        async_reset();
        step();
        rst_n = 1'b1;
        step();
        bus.i_rec_addr = 20'h00123;
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        bus.i_rec_addr = 20'h00200;
        press(0, 0, 1, 0);
        check_val("s7_valid_before", 32'(bus.o_slot_valid), 32'b0001);
        press(1, 0, 0, 0);
        bus.i_rec_addr = 20'h00300;
        step();
        check_val("s7_recd", 32'(bus.o_state), 32'(ST_RECD));
        async_reset();
        check_val("s7_state", 32'(bus.o_state), 32'(ST_INIT));
        check_val("s7_ctl",   32'({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                                   bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop}), 32'd0);
        check_val("s7_valid", 32'(bus.o_slot_valid), 32'd0);
        check_val("s7_we_n",  32'(bus.o_sram_we_n), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        check_val("s7_no_spurious", 32'(bus.o_rec_start), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aud_session_ctrl.md
AUD_SESSION_CTRL -- requirements
Module: aud_session_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 4, sets the number of independent recording slots; it SHALL be a power of two, from 2 to 16.
REQ-002 Parameter ADDR_W, default 20, sets the SRAM word-address width.
REQ-003 Port i_clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port i_i2c_fin, input, 1 bit: codec initialisation done, held high once reached.
REQ-006 Ports i_key_rec, i_key_play, i_key_stop and i_key_slot, input, 1 bit each: already-debounced key presses, each one cycle wide.
REQ-007 Port i_loop, input, 1 bit: loop-playback mode enable.
REQ-008 Port i_rec_addr, input, ADDR_W bits: the recorder's current write address.
REQ-009 Ports i_rec_fin and i_play_fin, input, 1 bit each: recorder-finished and DSP-finished pulses.
REQ-010 Ports o_rec_start, o_rec_pause and o_rec_stop, output, 1 bit each: recorder control levels.
REQ-011 Ports o_dsp_start, o_dsp_pause and o_dsp_stop, output, 1 bit each: DSP control levels.
REQ-012 Port o_slot, output, $clog2(NUM_SLOTS) bits: the selected slot index.
REQ-013 Port o_slot_base, output, ADDR_W bits: the first address of the selected slot.
REQ-014 Port o_slot_end, output, ADDR_W bits: the last recorded address of the selected slot, used as the DSP stop address.
REQ-015 Port o_slot_valid, output, NUM_SLOTS bits: one bit per slot, set when that slot holds a recording.
REQ-016 Port o_sram_we_n, output, 1 bit: SRAM write enable, active low; low only in RECD.
REQ-017 Port o_state, output, 3 bits: the current FSM state encoding.

Function
REQ-018 States SHALL be INIT, IDLE, RECD, RECD_PAUSE, PLAY, PLAY_PAUSE and LOOP.
REQ-019 INIT SHALL move to IDLE on the first cycle in which i_i2c_fin=1; while in INIT, all keys SHALL be ignored.
REQ-020 When keys coincide, priority SHALL be stop > rec > play > slot.
REQ-021 IDLE transitions:
- key_rec -> RECD, with rec_start=1 and rec_stop=0.
- key_play -> PLAY, with dsp_start=1 and dsp_stop=0, only if o_slot_valid[o_slot]=1; otherwise the key is ignored.
- key_slot -> o_slot increments, wrapping from NUM_SLOTS-1 to 0.
REQ-022 RECD transitions:
- key_stop, i_rec_fin or slot-full -> IDLE, with rec_stop=1 and rec_start=0.
- key_rec -> RECD_PAUSE, with rec_pause=1 and rec_start=0.
REQ-023 RECD_PAUSE transitions:
- key_stop -> IDLE, with rec_stop=1 and rec_pause=0.
- key_rec -> RECD, with rec_start=1 and rec_pause=0.
REQ-024 PLAY and PLAY_PAUSE SHALL mirror RECD and RECD_PAUSE using key_play and the dsp_* outputs; i_play_fin with i_loop=0 SHALL act as key_stop.
REQ-025 i_play_fin in PLAY with i_loop=1 SHALL enter LOOP, with dsp_stop=1 and dsp_start=0, for exactly one cycle, then return to PLAY with dsp_start=1 and dsp_stop=0.
REQ-026 Slot geometry: SLOT_SIZE = 2^ADDR_W / NUM_SLOTS; o_slot_base = o_slot * SLOT_SIZE, computed as a constant shift with no multiplier.
REQ-027 Slot-full SHALL be detected when i_rec_addr = o_slot_base + SLOT_SIZE - 1 while in RECD; the controller SHALL force stop on the same edge as any other stop cause.
REQ-028 On leaving RECD or RECD_PAUSE for IDLE, the controller SHALL latch i_rec_addr into that slot's end register and set its valid bit.
REQ-029 A stop with i_rec_addr = o_slot_base SHALL set the valid bit to 0, since the recording is empty.
REQ-030 Starting a new recording SHALL clear the selected slot's valid bit on the IDLE->RECD edge.
REQ-031 o_slot_end SHALL be the end register of the current o_slot.
REQ-032 o_slot SHALL change only in IDLE.
REQ-033 All control outputs SHALL be registered levels that update one cycle after the causing key or pulse; combinational key-to-output paths are forbidden.
REQ-034 Keys arriving in a state that does not consume them SHALL be ignored; the controller SHALL not buffer them.

Reset
REQ-035 On i_rst_n=0 the block SHALL asynchronously enter:
- state INIT;
- all start, pause and stop outputs = 0;
- o_slot = 0;
- o_slot_valid = 0;
- all end registers = 0;
- o_sram_we_n = 1.
REQ-036 Reset asserted mid-record or mid-play SHALL discard the in-progress slot; that slot's valid bit SHALL be 0 afterwards.
REQ-037 Release of reset SHALL be followed by normal INIT behaviour, with no spurious start pulse.

Structure
REQ-038 A shared package SHALL hold the state enum, the default values of NUM_SLOTS and ADDR_W, and a SLOT_SIZE function.
REQ-039 One sub-module, aud_slot_table, SHALL hold the per-slot end registers and valid bits, with write and clear ports and an indexed read.

Verification
REQ-040 The bench SHALL cover each of the following scenarios:
- Scenario 1: with i_i2c_fin=0, pulse key_rec -> state stays INIT. Then raise i2c_fin -> IDLE on the next cycle.
- Scenario 2: slot 2 with NUM_SLOTS=4 and ADDR_W=20 -> o_slot_base=0x80000. Record, then key_stop with i_rec_addr=0x80123 -> o_slot_end=0x80123 and o_slot_valid=4'b0100.
- Scenario 3: record with i_rec_addr ramping to 0x3FFFF in slot 0 -> auto-stop, with rec_stop=1 one cycle later and o_slot_end=0x3FFFF.
- Scenario 4: key_play on an empty slot -> stays IDLE with dsp_start=0. On a valid slot with i_loop=1, i_play_fin -> one LOOP cycle (dsp_stop=1), then PLAY with dsp_start=1.
- Scenario 5: key_stop and key_rec in the same cycle while in IDLE -> remains IDLE.
- Scenario 6: key_slot four times -> o_slot wraps 0,1,2,3,0.
- Scenario 7: reset during RECD -> INIT, all outputs 0, and that slot's valid bit = 0.
